// File: rtl/ranged_onehot_decoder.sv
// ranged_onehot_decoder
//   Decodes in_binary into a one-hot word whose bit 0 corresponds to BASE.
//   Values below BASE, or at/above BASE+OUTPUT_WIDTH, produce a miss
//   instead of a one-hot bit. There is one registered result stage with a
//   valid/ready handshake on each side. A drain and a new load can happen
//   in the same cycle, so the stage sustains one result per cycle.
//
//   Optional feature: define RANGED_ONEHOT_DECODER_MISS_COUNT_EN to build
//   a saturating counter of accepted misses. Without the macro, miss_count
//   is tied to 0 and miss_clear is ignored.
//
// Ports
//   clock       sole clock, rising edge
//   reset_n     synchronous active-low reset
//   in_binary   value to decode
//   in_valid    in_binary valid this cycle
//   in_ready    stage can take in_binary this cycle (combinational)
//   out_onehot  registered one-hot result
//   out_miss    registered: accepted value mapped to no output bit
//   out_valid   out_onehot/out_miss hold a result
//   out_ready   consumer takes the result this cycle
//   miss_clear  synchronous miss counter clear
//   miss_count  saturating count of accepted misses
module ranged_onehot_decoder #(
    parameter int unsigned             BINARY_WIDTH     = 8,
    parameter int unsigned             OUTPUT_WIDTH     = 16,
    parameter logic [BINARY_WIDTH-1:0] BASE             = '0,
    parameter int unsigned             MISS_COUNT_WIDTH = 16
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic [BINARY_WIDTH-1:0]     in_binary,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic [OUTPUT_WIDTH-1:0]     out_onehot,
    output logic                        out_miss,
    output logic                        out_valid,
    input  logic                        out_ready,
    input  logic                        miss_clear,
    output logic [MISS_COUNT_WIDTH-1:0] miss_count
);

    localparam int unsigned OFFSET_WIDTH = BINARY_WIDTH + 1;

    logic [OFFSET_WIDTH-1:0] offset;
    logic                    in_range;
    logic [OUTPUT_WIDTH-1:0] decoded;
    logic                    accept;

    // The stage is free when empty or when its current result drains this cycle.
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    // The extra offset bit keeps the subtraction exact. The explicit
    // lower-bound test is still needed: when OUTPUT_WIDTH exceeds
    // 2^BINARY_WIDTH, a wrapped negative offset could otherwise look in range.
    assign offset   = {1'b0, in_binary} - {1'b0, BASE};
    assign in_range = (in_binary >= BASE) && (64'(offset) < 64'(OUTPUT_WIDTH));

    // One-hot decode of the offset; all zero on a miss.
    always_comb begin
        decoded = '0;
        for (int unsigned i = 0; i < OUTPUT_WIDTH; i++) begin
            if (in_range && (64'(offset) == 64'(i))) begin
                decoded[i] = 1'b1;
            end
        end
    end

    // Result stage: a load has priority over a drain, which allows back-to-back results.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            out_valid  <= 1'b0;
            out_onehot <= '0;
            out_miss   <= 1'b0;
        end else if (accept) begin
            out_valid  <= 1'b1;
            out_onehot <= decoded;
            out_miss   <= !in_range;
        end else if (out_valid && out_ready) begin
            out_valid  <= 1'b0;
            out_onehot <= '0;
            out_miss   <= 1'b0;
        end
    end

`ifdef RANGED_ONEHOT_DECODER_MISS_COUNT_EN
    logic [MISS_COUNT_WIDTH-1:0] count_q;

    // Saturating miss counter; a clear wins over a same-cycle increment.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            count_q <= '0;
        end else if (miss_clear) begin
            count_q <= '0;
        end else if (accept && !in_range && (count_q != '1)) begin
            count_q <= count_q + MISS_COUNT_WIDTH'(1);
        end
    end

    assign miss_count = count_q;
`else
    logic unused_miss_clear;

    assign unused_miss_clear = miss_clear;
    assign miss_count        = '0;
`endif

endmodule

// File: doc/ranged_onehot_decoder.md
RANGED_ONEHOT_DECODER -- requirements
Module: ranged_onehot_decoder

Interface
REQ-001 SHALL have parameter BINARY_WIDTH, default 8: input binary word width, 1..32.
REQ-002 SHALL have parameter OUTPUT_WIDTH, default 16: one-hot output width, >=1; may be more or less than 2^BINARY_WIDTH.
REQ-003 SHALL have parameter BASE, default 0: binary value mapped to out_onehot[0], 0..2^BINARY_WIDTH-1.
REQ-004 SHALL have parameter MISS_COUNT_WIDTH, default 16: miss counter width, >=1.
REQ-005 SHALL have port clock  in  1  sole clock; all state updates on rising edge.
REQ-006 SHALL have port reset_n  in  1  one clock; reset is synchronous and active-low.
REQ-007 SHALL have port in_binary  in  BINARY_WIDTH  value to decode.
REQ-008 SHALL have port in_valid  in  1  in_binary valid this cycle.
REQ-009 SHALL have port in_ready  out  1  block accepts in_binary this cycle.
REQ-010 SHALL have port out_onehot  out  OUTPUT_WIDTH  registered one-hot decode result.
REQ-011 SHALL have port out_miss  out  1  registered: accepted value mapped to no output bit.
REQ-012 SHALL have port out_valid  out  1  out_onehot/out_miss hold a result.
REQ-013 SHALL have port out_ready  in  1  consumer takes result this cycle.
REQ-014 SHALL have port miss_clear  in  1  synchronous miss counter clear.
REQ-015 SHALL have port miss_count  out  MISS_COUNT_WIDTH  accepted-miss count.

Function
REQ-016 SHALL accept an input ("accept") in any cycle where in_valid and in_ready are both 1.
REQ-017 SHALL drive in_ready = (not out_valid) or out_ready, combinationally; no other input affects it.
REQ-018 SHALL present an accepted result with exactly 1 cycle latency: out_valid=1 on the following cycle.
REQ-019 SHALL compute offset = in_binary - BASE at BINARY_WIDTH+1 bits; hit iff in_binary >= BASE and offset < OUTPUT_WIDTH.
REQ-020 SHALL, on accept with hit, load out_onehot with only bit [offset] set and out_miss=0.
REQ-021 SHALL, on accept with miss, load out_onehot=0 and out_miss=1.
REQ-022 SHALL hold out_onehot, out_miss, out_valid unchanged while out_valid=1 and out_ready=0.
REQ-023 SHALL, when out_valid=1, out_ready=1 and no accept, clear out_valid, out_onehot, out_miss to 0 next cycle.
REQ-024 SHALL, on simultaneous drain and accept, load the new result with out_valid remaining 1 (one result per cycle sustained).
REQ-025 SHALL never set more than one out_onehot bit, and SHALL keep out_onehot=0 and out_miss=0 whenever out_valid=0.
REQ-026 SHALL ignore in_binary when in_valid=0 and ignore out_ready when out_valid=0.

Reset
REQ-027 SHALL, with reset_n=0 at a rising edge, set out_valid=0, out_onehot=0, out_miss=0, miss_count=0, overriding any accept, drain or clear that cycle.
REQ-028 SHALL drop any in-flight result on reset mid-operation; in_ready reads 1 the cycle after reset.

Configuration
REQ-029 SHALL compile the miss counter only when macro RANGED_ONEHOT_DECODER_MISS_COUNT_EN is defined.
REQ-030 SHALL, with macro defined, increment miss_count by 1 per accepted miss, saturating at all-ones, no wrap.
REQ-031 SHALL, with macro defined, clear miss_count to 0 when miss_clear=1; clear wins over a same-cycle increment.
REQ-032 SHALL, without macro, tie miss_count to 0, ignore miss_clear and keep ports and decode behaviour identical.

Verification
REQ-033 SHALL cover: BW=8, OW=16, BASE=4; in=4 accepted, out_ready=1 -> next cycle out_valid=1, out_onehot=0x0001, out_miss=0.
REQ-034 SHALL cover: same config; in=19 -> 0x8000 miss=0; in=20 -> 0x0000 miss=1; in=3 -> 0x0000 miss=1; in=255 -> miss=1.
REQ-035 SHALL cover: result pending, out_ready=0 for 3 cycles -> in_ready=0, outputs frozen; then out_ready=1 and in_valid=1 every cycle -> one result per cycle, no gaps, no loss.
REQ-036 SHALL cover: reset_n=0 for 1 cycle while out_valid=1 and in_valid=1 -> next cycle out_valid=0, out_onehot=0, miss_count=0, in_ready=1.
REQ-037 SHALL cover, macro defined, MISS_COUNT_WIDTH=2: 5 accepted misses -> miss_count=3; miss_clear with same-cycle accepted miss -> 0; macro undefined -> miss_count stays 0.
REQ-038 SHALL cover: BW=3, OW=12, BASE=0; in=0..7 -> bits 0..7 singly, bits 8..11 never set, out_miss never 1.
